// File: rtl/song_autoplayer.sv
// song_autoplayer
// Autonomous melody source for the FPGA piano. Plays the stored 59-note
// Do-Re-Mi training melody on the 4-bit note bus. Each note is held for
// NOTE_CYCLES clocks and is followed by GAP_CYCLES clocks of `none`, so a
// downstream follower sees the same note/none alternation a player makes.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_N  in   asynchronous active-low reset
//   START    in   start playback from note 0, or restart it if already playing
//   STOP     in   abort playback and return to idle (beats START)
//   PAUSE    in   level; freezes state, duration counter and index
//   note     out  registered note code (0 = none, 1..8 = C4..C5)
//   busy     out  registered, high while playing a note or a gap
//   done     out  registered one-cycle pulse when the melody ends naturally
//   idx      out  registered index (0..58) of the current melody note
module song_autoplayer #(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       PAUSE,
  output logic [3:0] note,
  output logic       busy,
  output logic       done,
  output logic [5:0] idx
);

  localparam int MAX_CYCLES = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [5:0]       LAST_IDX  = 6'd58;

  // Melody ROM, padded to 64 entries with `none` so every 6-bit index is
  // covered; idx never reaches the padding.
  localparam logic [3:0] MELODY [64] = '{
    4'd1, 4'd2, 4'd3, 4'd1, 4'd3, 4'd1, 4'd3, 4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2, 4'd4, 4'd3, 4'd4,
    4'd5, 4'd3, 4'd5, 4'd3, 4'd5, 4'd4, 4'd5, 4'd6, 4'd6, 4'd5, 4'd4, 4'd6, 4'd5, 4'd1, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd8, 4'd8, 4'd7, 4'd6, 4'd4, 4'd7, 4'd5, 4'd8, 4'd5, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [5:0]       w_idx_next;
  logic [3:0]       w_note_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic             w_frozen;

  // Pause only freezes an active playback; in idle (or an illegal encoding)
  // the normal path runs so recovery is never blocked.
  assign w_frozen = PAUSE && ((r_state == S_PLAY) || (r_state == S_GAP));

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = idx;
    w_done_next  = 1'b0;

    if (STOP) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_idx_next   = '0;
    end else if (START) begin
      w_state_next = S_PLAY;
      w_cnt_next   = NOTE_LOAD;
      w_idx_next   = '0;
    end else if (!w_frozen) begin
      case (r_state)
        S_IDLE: begin
          w_cnt_next = '0;
          w_idx_next = '0;
        end
        S_PLAY: begin
          if (r_cnt == '0) begin
            w_state_next = S_GAP;
            w_cnt_next   = GAP_LOAD;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
          end else if (idx >= LAST_IDX) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_PLAY;
            w_cnt_next   = NOTE_LOAD;
            w_idx_next   = idx + 6'd1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_idx_next   = '0;
        end
      endcase
    end

    // Outputs are computed from the next state so they can be registered
    // and still line up with the state they describe.
    w_note_next = (w_state_next == S_PLAY) ? MELODY[w_idx_next] : 4'd0;
    w_busy_next = (w_state_next == S_PLAY) || (w_state_next == S_GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      idx     <= '0;
      note    <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      idx     <= w_idx_next;
      note    <= w_note_next;
      busy    <= w_busy_next;
      done    <= w_done_next;
    end
  end

endmodule

// File: tb/tb_song_autoplayer.sv
// Testbench for song_autoplayer with NOTE_CYCLES=4, GAP_CYCLES=2.
// The driver applies one input vector per clock and pushes the expected
// outputs for the following cycle into a queue; a separate monitor pops and
// compares on the falling edge (or on demand for the async reset check).
// Expected values come from the song timeline: after START, each unpaused
// edge advances a position p; note slot = p/6, phase = p%6 (0..3 note,
// 4..5 gap); p reaching 354 ends the song with a done pulse.
module tb_song_autoplayer;

  localparam int NC       = 4;
  localparam int GC       = 2;
  localparam int SLOT     = NC + GC;
  localparam int LAST_POS = 59 * SLOT;

  localparam logic [3:0] MEL [59] = '{
    4'd1, 4'd2, 4'd3, 4'd1, 4'd3, 4'd1, 4'd3, 4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2, 4'd4, 4'd3, 4'd4,
    4'd5, 4'd3, 4'd5, 4'd3, 4'd5, 4'd4, 4'd5, 4'd6, 4'd6, 4'd5, 4'd4, 4'd6, 4'd5, 4'd1, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd8, 4'd8, 4'd7, 4'd6, 4'd4, 4'd7, 4'd5, 4'd8, 4'd5, 4'd3, 4'd2
  };

  typedef struct packed {
    logic [3:0] note;
    logic       busy;
    logic       done;
    logic [5:0] idx;
  } exp_t;

  logic       CLK;
  logic       RESET_N;
  logic       START;
  logic       STOP;
  logic       PAUSE;
  logic [3:0] note;
  logic       busy;
  logic       done;
  logic [5:0] idx;

  exp_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  bit   playing   = 0;
  int   pos       = 0;
  bit   done_flag = 0;
  int   cyc       = 0;
  int   done_cyc  = -1;
  event sample_ev;

  song_autoplayer #(
    .NOTE_CYCLES(NC),
    .GAP_CYCLES (GC)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .START  (START),
    .STOP   (STOP),
    .PAUSE  (PAUSE),
    .note   (note),
    .busy   (busy),
    .done   (done),
    .idx    (idx)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   slot;
    int   ph;
    e = '0;
    if (playing) begin
      slot   = pos / SLOT;
      ph     = pos % SLOT;
      e.note = (ph < NC) ? MEL[slot] : 4'd0;
      e.busy = 1'b1;
      e.idx  = 6'(slot);
    end else begin
      e.done = done_flag;
    end
    return e;
  endfunction

  // One clock: drive inputs, advance the reference timeline at the edge,
  // queue the expected outputs for the cycle that follows.
  task automatic step(input bit st, input bit sp, input bit pa);
    START = st;
    STOP  = sp;
    PAUSE = pa;
    @(posedge CLK);
    done_flag = 0;
    if (!RESET_N) begin
      playing = 0;
    end else if (sp) begin
      playing = 0;
    end else if (st) begin
      playing = 1;
      pos     = 0;
    end else if (!pa && playing) begin
      pos++;
      if (pos == LAST_POS) begin
        playing   = 0;
        done_flag = 1;
      end
    end
    if (st && !sp && RESET_N) cyc = 1;
    else cyc++;
    exp_q.push_back(model_out());
    #1;
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or sample_ev);
      if (done === 1'b1) done_cyc = cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("note", int'(note), int'(e.note));
        check("busy", int'(busy), int'(e.busy));
        check("done", int'(done), int'(e.done));
        check("idx",  int'(idx),  int'(e.idx));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    STOP    = 1'b0;
    PAUSE   = 1'b0;

    // 1. Reset with random inputs, then idle with no START.
    repeat (4) step(1'($urandom), 1'($urandom), 1'($urandom));
    RESET_N = 1'b1;
    repeat (6) step(0, 0, 0);
    repeat (3) step(0, 0, 1);

    // 2. Full song.
    done_cyc = -1;
    step(1, 0, 0);
    repeat (LAST_POS + 3) step(0, 0, 0);
    check("done_cycle_full_song", done_cyc, 355);

    // 3. Pause for 10 cycles from cycle 2.
    done_cyc = -1;
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (10) step(0, 0, 1);
    repeat (LAST_POS + 6) step(0, 0, 0);
    check("done_cycle_paused", done_cyc, 365);

    // 4. STOP at idx 5 in PLAY, then START+STOP together in idle.
    done_cyc = -1;
    step(1, 0, 0);
    repeat (5 * SLOT) step(0, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    step(1, 1, 0);
    repeat (4) step(0, 0, 0);
    check("no_done_after_stop", done_cyc, -1);

    // 5. Restart at idx 20, START held, START with PAUSE.
    done_cyc = -1;
    step(1, 0, 0);
    repeat (20 * SLOT) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    repeat (8) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    check("no_done_after_restart", done_cyc, -1);

    // 6. Asynchronous reset between edges at idx 30.
    step(1, 0, 0);
    repeat (30 * SLOT) step(0, 0, 0);
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    exp_q.push_back(exp_t'(0));
    ->sample_ev;
    @(posedge CLK);
    #1;
    repeat (2) step(0, 0, 0);
    RESET_N = 1'b1;
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    step(0, 1, 0);

    @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/song_autoplayer.md
# song_autoplayer

Autonomous melody source for the FPGA piano. It plays the stored 59-note Do-Re-Mi training melody by driving the 4-bit `note` bus, with no user input during playback. Each melody note is followed by a `none` gap, so a downstream note follower sees the same note/none alternation a player produces on the switches. It sits between the control buttons and the note-decode/tone path, in parallel with the switch-derived note source. It also serves as the demo mode and as the stimulus source for the tutor block.

## Interface
- `NOTE_CYCLES`, default 25_000_000: clock cycles each melody note is held; must be ≥ 1.
- `GAP_CYCLES`, default 5_000_000: clock cycles of `none` after each note; must be ≥ 1.
- `CLK` input, 1 bit: single system clock. All logic is on its rising edge.
- `RESET_N` input, 1 bit: reset, asynchronous and active-low.
- `START` input, 1 bit: synchronous, sampled each edge. Begins playback from note 0, or restarts playback if already playing.
- `STOP` input, 1 bit: synchronous. Aborts playback and returns to IDLE.
- `PAUSE` input, 1 bit: level. While high, the FSM state, duration counter and index are frozen.
- `note` output, 4 bits: registered note code. Encoding: none=0, C4=1, D=2, E=3, F=4, G=5, A=6, B=7, C5=8.
- `busy` output, 1 bit: registered. High in PLAY and GAP.
- `done` output, 1 bit: registered one-cycle pulse when the melody completes naturally.
- `idx` output, 6 bits: registered index (0..58) of the current melody note.

## Operation
- Melody ROM, 59 entries, combinational lookup by `idx`, in order:
  - C D E C E C E D E F F E D F E F
  - G E G E G F G A A G F A G C D E
  - F G A A D E F G A B B E F G A B
  - C5 C5 B A F B G C5 G E D
- FSM states and transitions:
  - IDLE: `note`=0, `busy`=0. On START, go to PLAY with `idx`=0 and the counter loaded.
  - PLAY: `note`=ROM[`idx`]. When the counter expires, go to GAP.
  - GAP: `note`=0. When the counter expires:
    - if `idx`<58, increment `idx` and go to PLAY;
    - if `idx`=58, go to IDLE, pulse `done`, and clear `idx` to 0.
- Duration counter:
  - Loaded with NOTE_CYCLES−1 on entry to PLAY and with GAP_CYCLES−1 on entry to GAP.
  - Decrements by one each unpaused cycle; expiry is counter=0.
  - Width is clog2 of max(NOTE_CYCLES, GAP_CYCLES), minimum 1.
- Priority, highest first: RESET_N, then STOP, then START, then PAUSE, then normal advance.
  - STOP in any state: go to IDLE, `note`=0, `busy`=0, `idx`=0, no `done`.
  - START in PLAY or GAP: restart at `idx`=0 in PLAY. A START held high keeps restarting at 0.
  - START while PAUSE is high: the restart still happens.
  - PAUSE in IDLE has no effect.
- Reset values: `note`=0, `busy`=0, `done`=0, `idx`=0, state IDLE, counter 0. After `RESET_N` rises, the block stays in IDLE until START.
- `idx` never exceeds 58. Any illegal state encoding recovers to IDLE.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- START sampled at edge k: `busy`=1 and `note`=C4 from cycle k+1.
- Each note occupies exactly NOTE_CYCLES cycles, followed by exactly GAP_CYCLES cycles of `note`=0.
- Total playback is 59×(NOTE_CYCLES+GAP_CYCLES) cycles.
- In the cycle after the last gap cycle: `done`=1 for exactly one cycle, `busy`=0, `note`=0.
- STOP at edge k: `note`=0 and `busy`=0 from cycle k+1.
- PAUSE high for P cycles extends the current note or gap by exactly P cycles.
- Asserting `RESET_N` mid-playback clears all outputs immediately, without waiting for a clock edge.

## Test plan
All scenarios use NOTE_CYCLES=4, GAP_CYCLES=2.
1. Reset: hold `RESET_N`=0 with random inputs, then release. Required: `note`=0, `busy`=0, `done`=0, `idx`=0; outputs remain unchanged with no START.
2. Full song: one-cycle START at cycle 0. Required:
   - cycles 1–4 `note`=1; cycles 5–6 `note`=0; cycles 7–10 `note`=2;
   - full sequence matches the ROM;
   - `done`=1 only at cycle 355, `busy`=0 from cycle 355.
3. Pause: PAUSE high for 10 cycles starting at cycle 2. Required: `note`=1 held through cycle 14, `note`=0 at cycles 15–16, `done` shifted to cycle 365.
4. Stop and START/STOP conflict:
   - STOP while `idx`=5 in PLAY. Required: next cycle `note`=0, `busy`=0, `idx`=0, and no `done` pulse ever.
   - START and STOP together in IDLE. Required: block stays in IDLE.
5. Restart: START again while `idx`=20. Required: next cycle `idx`=0, `note`=1 for 4 cycles, `busy` stays 1 throughout, no `done`.
6. Async reset mid-song: drop `RESET_N` between clock edges at `idx`=30. Required:
   - outputs clear before the next edge;
   - after release the block is idle;
   - a later START plays from `note`=1.
